// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE multicycle core sequencer.
// Holds the state encoding and the default phase count.
package simple_pkg;

  localparam int DEF_NPHASE = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/phase_sequencer_retire_counter.sv
// Retired-instruction counter: wraps modulo 2**CNT_W, bumps once per enabled cycle.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase instruction sequencer: one-hot single-cycle phase enables with
// run/step/halt modes, early skip, stall and a retired-instruction counter.
module phase_sequencer
  import simple_pkg::*;
#(
  parameter int NPHASE = DEF_NPHASE,
  parameter int PW     = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              skip,
  input  logic              stall,
  input  logic              resume,
  output logic [NPHASE-1:0] phase_en,
  output logic [PW-1:0]     phase_idx,
  output logic              last_phase,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  state_t        state, state_next;
  logic [PW-1:0] idx, idx_next;
  logic          in_instr, active, retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Mode is only re-evaluated once an instruction retires, so a run change
  // mid-instruction lets the current instruction finish.
  always_comb begin
    in_instr   = (state == ST_RUN) || (state == ST_STEP);
    active     = in_instr && !stall;
    last_phase = in_instr && (skip || (idx == PW'(NPHASE - 1)));
    retire     = active && last_phase;
    phase_en   = '0;
    state_next = state;
    idx_next   = idx;

    if (active) begin
      phase_en = NPHASE'(1) << idx;
      idx_next = last_phase ? '0 : idx + PW'(1);
    end

    case (state)
      ST_IDLE: begin
        if (run) begin
          state_next = ST_RUN;
        end else if (step) begin
          state_next = ST_STEP;
        end
      end
      ST_RUN, ST_STEP: begin
        if (retire) begin
          if (halt_req) begin
            state_next = ST_HALT;
          end else if ((state == ST_STEP) || !run) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_HALT: begin
        idx_next = '0;
        if (resume) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign phase_idx = idx;
  assign running   = in_instr;
  assign halted    = (state == ST_HALT);

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire (
    .clk  (clk),
    .reset(reset),
    .en   (retire),
    .count(instr_count)
  );

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer: a 5-phase/16-bit instance
// and a 3-phase/4-bit instance for period and counter-wrap checks.
module tb_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, step, halt_req, skip, stall, resume;
  logic [4:0]  phase_en;
  logic [3:0]  phase_idx;
  logic        last_phase, running, halted;
  logic [15:0] instr_count;

  logic        reset3, run3;
  logic        zero_in = 1'b0;
  logic [2:0]  phase_en3;
  logic [1:0]  phase_idx3;
  logic        last3, running3, halted3;
  logic [3:0]  count3;

  int checks = 0;
  int passes = 0;

  phase_sequencer #(.NPHASE(5), .PW(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .skip(skip), .stall(stall), .resume(resume), .phase_en(phase_en),
    .phase_idx(phase_idx), .last_phase(last_phase), .running(running),
    .halted(halted), .instr_count(instr_count)
  );

  phase_sequencer #(.NPHASE(3), .PW(2), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset3), .run(run3), .step(zero_in), .halt_req(zero_in),
    .skip(zero_in), .stall(zero_in), .resume(zero_in), .phase_en(phase_en3),
    .phase_idx(phase_idx3), .last_phase(last3), .running(running3),
    .halted(halted3), .instr_count(count3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic h,
                               input logic k, input logic st, input logic rs);
    run = r; step = s; halt_req = h; skip = k; stall = st; resume = rs;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; reset3 = 1'b1; run3 = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    reset = 1'b0;

    // reset state
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rst_en", 32'(phase_en), 32'h0);
    checkOutput("rst_idx", 32'(phase_idx), 32'h0);
    checkOutput("rst_cnt", 32'(instr_count), 32'h0);
    checkOutput("rst_running", 32'(running), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_last", 32'(last_phase), 32'h0);

    // free run: IDLE cycle, then three gapless instructions
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("fr_idle_en", 32'(phase_en), 32'h0);
    nextCycle();
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("fr_en", 32'(phase_en), 32'(1) << (k % 5));
      checkOutput("fr_cnt", 32'(instr_count), 32'(k / 5));
      nextCycle();
    end
    checkOutput("fr_cnt3", 32'(instr_count), 32'd3);
    // run drops at phase 0: the instruction still completes, then IDLE
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("drain_en", 32'(phase_en), 32'(1) << k);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("drain_running", 32'(running), 32'h0);
    checkOutput("drain_en_idle", 32'(phase_en), 32'h0);
    checkOutput("drain_cnt", 32'(instr_count), 32'd4);

    // single step, extra pulse in phase 2 ignored
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("st_idle_en", 32'(phase_en), 32'h0);
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, (k == 2), 0, 0, 0, 0);
      checkOutput("st_en", 32'(phase_en), 32'(1) << k);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("st_done_running", 32'(running), 32'h0);
    checkOutput("st_done_en", 32'(phase_en), 32'h0);
    checkOutput("st_cnt", 32'(instr_count), 32'd5);
    nextCycle();
    checkOutput("st_no_queue_en", 32'(phase_en), 32'h0);

    // stall in phase 1 then skip in phase 2, in RUN
    applyStimulus(1, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("ss_p0_en", 32'(phase_en), 32'h1);
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, (k == 2), (k == 1), 1, 0);
      checkOutput("stall_en", 32'(phase_en), 32'h0);
      checkOutput("stall_idx", 32'(phase_idx), 32'h1);
      nextCycle();
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("stall_release_en", 32'(phase_en), 32'h2);
    nextCycle();
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("skip_last", 32'(last_phase), 32'h1);
    checkOutput("skip_en", 32'(phase_en), 32'h4);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("skip_next_en", 32'(phase_en), 32'h1);
    checkOutput("skip_next_idx", 32'(phase_idx), 32'h0);
    checkOutput("skip_cnt", 32'(instr_count), 32'd6);
    nextCycle();

    // halt: ignored on phase 3, taken on phase 4
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("h_p1_en", 32'(phase_en), 32'h2);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("h_p2_en", 32'(phase_en), 32'h4);
    nextCycle();
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("h_p3_en", 32'(phase_en), 32'h8);
    checkOutput("h_p3_last", 32'(last_phase), 32'h0);
    nextCycle();
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("h_p4_en", 32'(phase_en), 32'h10);
    checkOutput("h_p4_last", 32'(last_phase), 32'h1);
    nextCycle();
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("halt_halted", 32'(halted), 32'h1);
    checkOutput("halt_en", 32'(phase_en), 32'h0);
    checkOutput("halt_idx", 32'(phase_idx), 32'h0);
    checkOutput("halt_running", 32'(running), 32'h0);
    checkOutput("halt_cnt", 32'(instr_count), 32'd7);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("halt_hold", 32'(halted), 32'h1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("halt_resume_cycle", 32'(halted), 32'h1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("resume_halted", 32'(halted), 32'h0);
    checkOutput("resume_running", 32'(running), 32'h0);
    checkOutput("resume_en", 32'(phase_en), 32'h0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("resume_run_en", 32'(phase_en), 32'h1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0);
    nextCycle();

    // reset mid-instruction at phase 3
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("mid_idx", 32'(phase_idx), 32'h3);
    checkOutput("mid_cnt", 32'(instr_count), 32'd7);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("mrst_en", 32'(phase_en), 32'h0);
    checkOutput("mrst_idx", 32'(phase_idx), 32'h0);
    checkOutput("mrst_cnt", 32'(instr_count), 32'h0);
    checkOutput("mrst_running", 32'(running), 32'h0);
    checkOutput("mrst_halted", 32'(halted), 32'h0);
    checkOutput("mrst_last", 32'(last_phase), 32'h0);

    // 3-phase instance: 3-cycle period and 4-bit counter wrap after 17 instructions
    reset3 = 1'b0;
    run3 = 1'b1;
    #1;
    checkOutput("n3_idle_en", 32'(phase_en3), 32'h0);
    nextCycle();
    for (int k = 0; k < 51; k++) begin
      checkOutput("n3_en", 32'(phase_en3), 32'(1) << (k % 3));
      if ((k % 3) == 0) checkOutput("n3_cnt", 32'(count3), 32'((k / 3) % 16));
      nextCycle();
    end
    checkOutput("n3_wrap_cnt", 32'(count3), 32'd1);
    checkOutput("n3_wrap_en", 32'(phase_en3), 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised multi-phase instruction sequencer for the SIMPLE multicycle core; successor to the fixed 5-phase gated-clock counter.
- Produces one-hot single-cycle phase enables (clock enables, not derived clocks) for IR/AR-BR/DR-SZCV/MDR-RF/PC updates.
- Adds run/single-step/halt modes, early phase skip, stall and a retired-instruction counter.
- Sits between the exec debouncer, ctl and the datapath registers.

Parameters:
- NPHASE, 5, number of phases per instruction (2..16).
- PW, 4, width of phase_idx; must satisfy 2**PW >= NPHASE.
- CNT_W, 16, width of instr_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = free-run mode, 0 = single-step mode.
- step  in  1  one-cycle pulse from the debouncer; starts exactly one instruction in step mode.
- halt_req  in  1  from ctl; sampled only on the last phase of an instruction.
- skip  in  1  from ctl; current phase becomes the instruction's last phase.
- stall  in  1  holds the current phase; no enable is asserted that cycle.
- resume  in  1  pulse; leaves HALT.
- phase_en  out  NPHASE  one-hot phase enable; all zero when not advancing.
- phase_idx  out  PW  current phase index.
- last_phase  out  1  current phase ends the instruction (idx==NPHASE-1 or skip).
- running  out  1  state is RUN or STEP.
- halted  out  1  state is HALT.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- States: IDLE, RUN, STEP, HALT.
- Reset (synchronous, takes priority over everything, including mid-instruction):
  - state=IDLE, phase_idx=0, phase_en=0, instr_count=0.
  - running=0, halted=0, last_phase=0.
- IDLE:
  - run=1 -> RUN next cycle.
  - else step=1 -> STEP next cycle.
  - phase_en stays 0.
- Active cycle (RUN or STEP with stall=0):
  - phase_en[phase_idx]=1 for exactly this cycle.
  - If last_phase: phase_idx<=0 and instr_count<=instr_count+1 (wraps modulo 2**CNT_W).
  - Otherwise: phase_idx<=phase_idx+1.
- stall=1 in RUN/STEP: phase_en=0, phase_idx held, count held. stall has priority over skip and halt_req.
- At the end of an instruction (last phase, not stalled), in priority order:
  - halt_req=1 -> HALT.
  - STEP -> IDLE.
  - RUN with run=0 -> IDLE.
  - Otherwise stay in RUN.
- A run change mid-instruction never aborts the instruction; mode is re-evaluated only at instruction end.
- step pulses while in RUN, STEP or HALT are ignored; pulses are not queued.
- HALT:
  - phase_en=0, halted=1, phase_idx=0.
  - resume=1 -> IDLE.
  - run/step have no effect until resume.
- skip on phase 0: that phase is the last, so a 1-phase instruction.
- last_phase is combinational from phase_idx, skip and state; 0 outside RUN/STEP.
- Latency: step pulse in cycle t -> phase_en[0] in cycle t+1 (if not stalled).
- Back-to-back instructions in RUN have no bubble: phase_en[0] follows phase_en[NPHASE-1] in the next cycle.

Decomposition:
- Shared package simple_pkg: state encoding constants (ST_IDLE, ST_RUN, ST_STEP, ST_HALT) and the default NPHASE.
- One natural sub-module: retire_counter (CNT_W-wide counter with synchronous reset and increment enable) for instr_count.
- The FSM and phase logic stay in phase_sequencer.

Test Plan:
- Free run: NPHASE=5, run=1 held after reset for 15 cycles -> phase_en walks 00001..10000 three times starting cycle 2; instr_count=3; no gaps.
- Single step: run=0, one step pulse -> phase_en 00001..10000 over 5 cycles, then IDLE. A second step pulse during phase 2 is ignored; instr_count=1.
- Skip and stall: skip asserted in phase 2 -> phase_en[3] never asserted and next phase_en is 00001. stall held 3 cycles in phase 1 -> phase_idx stays 1, phase_en=0 for 3 cycles, then phase_en=00010.
- Halt: halt_req=1 in phase 3 -> no effect. halt_req=1 in phase 4 -> HALT, halted=1, instr_count incremented, run ignored. resume -> IDLE; with run=1 -> RUN the following cycle.
- Reset mid-instruction: reset at phase 3 with instr_count=7 -> next cycle all outputs 0, state IDLE.
- Wrap and parameters: CNT_W=4, 17 instructions -> instr_count=1. Re-run the free-run case with NPHASE=3 -> 3-cycle period.
